ahb_rr_arbiter: RTL and testbench

- Per-slave round-robin arbiter for the AHB multi-master switch; one instance per slave port.
- Decides which master owns the slave's address phase and tracks which master owns the data phase.
- Replaces fixed master-0-first priority with fair rotation.
- Holds the grant across SEQ/BUSY bursts and HLOCK sequences.
- Bounds unlocked ownership with a hold limit.

---
 rtl/ahb_pkg.sv | 26 ++
 rtl/rr_pick.sv | 36 +++
 rtl/ahb_rr_arbiter.sv | 170 +++++++++++++++++
 tb/tb_ahb_rr_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB definitions for the multi-master switch: HTRANS codes,
// arbiter state encoding and index sizing.
package ahb_pkg;

    localparam int unsigned MAX_MASTERS = 16;
    localparam int unsigned IDX_W       = 4;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OWNED,
        ARB_LOCKED
    } arb_state_e;

    // A transfer boundary: the owner is not inside a SEQ/BUSY burst.
    function automatic logic is_rearb_trans(input logic [1:0] t);
        return (t == HTRANS_IDLE) || (t == HTRANS_NONSEQ);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first requester after last_idx, wrapping,
// optionally skipping one index.
module rr_pick
    import ahb_pkg::*;
#(
    parameter int unsigned MASTERS = 3
) (
    input  logic [MASTERS-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    input  logic               excl_en,
    input  logic [IDX_W-1:0]   excl_idx,
    output logic [MASTERS-1:0] win,
    output logic [IDX_W-1:0]   win_idx,
    output logic               found
);

    // Pass 0 scans indices above last_idx, pass 1 wraps to 0..last_idx;
    // this ordering is the round-robin order without any modulo arithmetic.
    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int unsigned p = 0; p < 2; p++) begin
            for (int unsigned j = 0; j < MASTERS; j++) begin
                if (!found && req[j]
                    && ((p == 0) ? (IDX_W'(j) > last_idx) : (IDX_W'(j) <= last_idx))
                    && !(excl_en && (IDX_W'(j) == excl_idx))) begin
                    win[j]  = 1'b1;
                    win_idx = IDX_W'(j);
                    found   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// Per-slave round-robin arbiter: owns the address-phase grant, holds it
// across bursts and locked sequences, and tracks the data-phase owner.
module ahb_rr_arbiter
    import ahb_pkg::*;
#(
    parameter int unsigned MASTERS  = 3,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                   HCLOCK,
    input  logic                   HRESETn,
    input  logic [MASTERS-1:0]     REQ,
    input  logic [MASTERS-1:0]     LOCK,
    input  logic [2*MASTERS-1:0]   TRANS,
    input  logic                   S_READY,
    output logic [MASTERS-1:0]     GRANT,
    output logic                   GRANT_VALID,
    output logic [IDX_W-1:0]       GRANT_IDX,
    output logic [IDX_W-1:0]       DATA_IDX,
    output logic                   DATA_VALID
);

    localparam int unsigned         HOLD_W   = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0]   HOLD_MAX = HOLD_W'(MAX_HOLD);

    arb_state_e           state_q, state_d;
    logic [MASTERS-1:0]   grant_q, grant_d;
    logic                 grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [IDX_W-1:0]     data_idx_q, data_idx_d;
    logic                 data_valid_q, data_valid_d;

    logic [MASTERS-1:0]   pick_win;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_found;
    logic                 pick_excl_en;

    assign pick_excl_en = (state_q != ARB_IDLE);

    rr_pick #(.MASTERS(MASTERS)) u_pick (
        .req      (REQ),
        .last_idx (last_q),
        .excl_en  (pick_excl_en),
        .excl_idx (grant_idx_q),
        .win      (pick_win),
        .win_idx  (pick_idx),
        .found    (pick_found)
    );

    // Next-state, grant, hold counter and data-phase tracking.
    always_comb begin
        logic [1:0]        trans_o;
        logic              lock_o;
        logic              req_o;
        logic              others;
        logic              rearb;
        logic              keep;
        logic [HOLD_W-1:0] hold_inc;

        state_d       = state_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        grant_idx_d   = grant_idx_q;
        last_d        = last_q;
        hold_d        = hold_q;
        data_idx_d    = data_idx_q;
        data_valid_d  = data_valid_q;

        trans_o = '0;
        lock_o  = 1'b0;
        req_o   = 1'b0;
        for (int unsigned m = 0; m < MASTERS; m++) begin
            if (grant_valid_q && (grant_idx_q == IDX_W'(m))) begin
                trans_o = TRANS[2*m +: 2];
                lock_o  = LOCK[m];
                req_o   = REQ[m];
            end
        end

        others   = |(REQ & ~grant_q);
        rearb    = S_READY && is_rearb_trans(trans_o) && !lock_o;
        hold_inc = (hold_q < HOLD_MAX) ? hold_q + 1'b1 : hold_q;
        keep     = (trans_o == HTRANS_NONSEQ) && req_o
                   && (!others || (MAX_HOLD == 0) || (hold_q < HOLD_MAX));

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_d       = pick_win;
                    grant_valid_d = 1'b1;
                    grant_idx_d   = pick_idx;
                    last_d        = pick_idx;
                    hold_d        = '0;
                    state_d       = |(LOCK & pick_win) ? ARB_LOCKED : ARB_OWNED;
                end
            end
            ARB_OWNED, ARB_LOCKED: begin
                if (lock_o) begin
                    state_d = ARB_LOCKED;
                    if (S_READY && (trans_o == HTRANS_NONSEQ)) begin
                        hold_d = hold_inc;
                    end
                end else if (!rearb) begin
                    state_d = ARB_OWNED;
                end else if (keep) begin
                    state_d = ARB_OWNED;
                    hold_d  = hold_inc;
                end else if (pick_found) begin
                    grant_d       = pick_win;
                    grant_valid_d = 1'b1;
                    grant_idx_d   = pick_idx;
                    last_d        = pick_idx;
                    hold_d        = '0;
                    state_d       = |(LOCK & pick_win) ? ARB_LOCKED : ARB_OWNED;
                end else if (req_o) begin
                    // Sole requester: re-grant in place with a fresh hold window.
                    state_d = ARB_OWNED;
                    hold_d  = '0;
                end else begin
                    state_d       = ARB_IDLE;
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    grant_idx_d   = '0;
                    hold_d        = '0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (S_READY) begin
            if (grant_valid_q && trans_o[1]) begin
                data_idx_d   = grant_idx_q;
                data_valid_d = 1'b1;
            end else begin
                data_valid_d = 1'b0;
            end
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge HCLOCK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q       <= ARB_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            last_q        <= IDX_W'(MASTERS - 1);
            hold_q        <= '0;
            data_idx_q    <= '0;
            data_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
            last_q        <= last_d;
            hold_q        <= hold_d;
            data_idx_q    <= data_idx_d;
            data_valid_q  <= data_valid_d;
        end
    end

    assign GRANT       = grant_q;
    assign GRANT_VALID = grant_valid_q;
    assign GRANT_IDX   = grant_idx_q;
    assign DATA_IDX    = data_idx_q;
    assign DATA_VALID  = data_valid_q;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed bench for ahb_rr_arbiter (3 masters, hold limit 8).
module tb_ahb_rr_arbiter;

    localparam logic [1:0] T_I = 2'b00;
    localparam logic [1:0] T_N = 2'b10;
    localparam logic [1:0] T_S = 2'b11;

    logic       HCLOCK = 1'b0;
    logic       HRESETn;
    logic [2:0] REQ;
    logic [2:0] LOCK;
    logic [5:0] TRANS;
    logic       S_READY;
    logic [2:0] GRANT;
    logic       GRANT_VALID;
    logic [3:0] GRANT_IDX;
    logic [3:0] DATA_IDX;
    logic       DATA_VALID;

    int n_tests = 0;
    int n_fail  = 0;

    ahb_rr_arbiter #(.MASTERS(3), .MAX_HOLD(8)) dut (
        .HCLOCK      (HCLOCK),
        .HRESETn     (HRESETn),
        .REQ         (REQ),
        .LOCK        (LOCK),
        .TRANS       (TRANS),
        .S_READY     (S_READY),
        .GRANT       (GRANT),
        .GRANT_VALID (GRANT_VALID),
        .GRANT_IDX   (GRANT_IDX),
        .DATA_IDX    (DATA_IDX),
        .DATA_VALID  (DATA_VALID)
    );

    always #5 HCLOCK = ~HCLOCK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, clock it, and settle just after the edge.
    task automatic cycle(input logic [2:0] req, input logic [2:0] lock,
                         input logic [5:0] trans, input logic rdy);
        REQ     = req;
        LOCK    = lock;
        TRANS   = trans;
        S_READY = rdy;
        @(posedge HCLOCK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] b_tr  [6];
        logic       b_rdy [6];
        logic [2:0] b_gnt [6];
        logic       b_dv  [6];

        HRESETn = 1'b0;
        REQ = '0; LOCK = '0; TRANS = '0; S_READY = 1'b1;
        repeat (2) @(posedge HCLOCK);
        #1;
        check("rst_grant", GRANT, 0);
        check("rst_gvalid", GRANT_VALID, 0);
        check("rst_gidx", GRANT_IDX, 0);
        check("rst_didx", DATA_IDX, 0);
        check("rst_dvalid", DATA_VALID, 0);
        @(negedge HCLOCK);
        HRESETn = 1'b1;

        // Rotation: each owner does one NONSEQ then goes IDLE.
        cycle(3'b111, 3'b000, {T_N, T_N, T_N}, 1'b1);
        check("rr_g0", GRANT, 3'b001);
        check("rr_g0_idx", GRANT_IDX, 0);
        check("rr_g0_dv", DATA_VALID, 0);
        cycle(3'b111, 3'b000, {T_N, T_N, T_N}, 1'b1);
        check("rr_g0_keep", GRANT, 3'b001);
        check("rr_d0_dv", DATA_VALID, 1);
        check("rr_d0_idx", DATA_IDX, 0);
        cycle(3'b111, 3'b000, {T_I, T_I, T_I}, 1'b1);
        check("rr_g1", GRANT, 3'b010);
        check("rr_g1_idx", GRANT_IDX, 1);
        check("rr_g1_dv", DATA_VALID, 0);
        cycle(3'b111, 3'b000, {T_N, T_N, T_N}, 1'b1);
        check("rr_d1_idx", DATA_IDX, 1);
        check("rr_d1_dv", DATA_VALID, 1);
        cycle(3'b111, 3'b000, {T_I, T_I, T_I}, 1'b1);
        check("rr_g2", GRANT, 3'b100);
        check("rr_g2_idx", GRANT_IDX, 2);
        cycle(3'b111, 3'b000, {T_N, T_N, T_N}, 1'b1);
        check("rr_d2_idx", DATA_IDX, 2);
        cycle(3'b111, 3'b000, {T_I, T_I, T_I}, 1'b1);
        check("rr_wrap", GRANT, 3'b001);

        // Master 1 INCR4 with wait state while 0 and 2 keep requesting.
        cycle(3'b111, 3'b000, {T_I, T_I, T_I}, 1'b1);
        check("burst_grant", GRANT, 3'b010);
        b_tr  = '{T_N, T_S, T_S, T_S, T_S, T_I};
        b_rdy = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        b_gnt = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b100};
        b_dv  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            cycle(3'b111, 3'b000, {T_I, b_tr[i], T_I}, b_rdy[i]);
            check($sformatf("burst_g%0d", i), GRANT, b_gnt[i]);
            check($sformatf("burst_dv%0d", i), DATA_VALID, b_dv[i]);
        end

        // Locked sequence on master 2 overrides the hold limit.
        for (int i = 0; i < 12; i++) begin
            cycle(3'b101, 3'b100, {T_N, T_I, T_I}, 1'b1);
            check($sformatf("lock_g%0d", i), GRANT, 3'b100);
        end
        cycle(3'b101, 3'b000, {T_N, T_I, T_I}, 1'b1);
        check("unlock_grant", GRANT, 3'b001);
        check("unlock_idx", GRANT_IDX, 0);

        // Hold limit: master 0 gets 9 accepted NONSEQ, then rotates.
        for (int i = 0; i < 8; i++) begin
            cycle(3'b011, 3'b000, {T_I, T_I, T_N}, 1'b1);
            check($sformatf("hold_g%0d", i), GRANT, 3'b001);
        end
        cycle(3'b011, 3'b000, {T_I, T_I, T_N}, 1'b1);
        check("hold_rotate", GRANT, 3'b010);

        // Asynchronous reset in the middle of a master-1 burst.
        cycle(3'b011, 3'b000, {T_I, T_N, T_I}, 1'b1);
        check("mid_grant", GRANT, 3'b010);
        cycle(3'b011, 3'b000, {T_I, T_S, T_I}, 1'b1);
        check("mid_dv", DATA_VALID, 1);
        check("mid_didx", DATA_IDX, 1);
        #2;
        HRESETn = 1'b0;
        #1;
        check("arst_grant", GRANT, 0);
        check("arst_gvalid", GRANT_VALID, 0);
        check("arst_dv", DATA_VALID, 0);
        @(posedge HCLOCK);
        @(negedge HCLOCK);
        HRESETn = 1'b1;
        REQ   = 3'b110;
        TRANS = {T_I, T_N, T_I};
        #1;
        check("rel_nogrant", GRANT, 0);
        @(posedge HCLOCK);
        #1;
        check("rel_grant", GRANT, 3'b010);
        check("rel_gidx", GRANT_IDX, 1);

        // Idle stretch, then a single requester.
        cycle(3'b000, 3'b000, {T_I, T_I, T_I}, 1'b1);
        check("idle_enter", GRANT_VALID, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(3'b000, 3'b000, {T_I, T_I, T_I}, 1'b1);
            check($sformatf("idle_gv%0d", i), GRANT_VALID, 0);
        end
        REQ   = 3'b100;
        TRANS = {T_N, T_I, T_I};
        #1;
        check("idle_nocomb", GRANT_VALID, 0);
        @(posedge HCLOCK);
        #1;
        check("idle_grant", GRANT, 3'b100);
        check("idle_gidx", GRANT_IDX, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
